// File: rtl/imem_responder.sv
// ---------------------------------------------------------------------------
// imem_responder
//
// Instruction-memory responder. It holds a word-addressed program store that
// is loaded through a write port. It answers one fetch request at a time with
// a fixed, parameterised latency.
//
// Parameters
//   DEPTH_WORDS  storage size in 32-bit words
//   WAIT_CYCLES  wait states between accept and response (0..15)
//   BASE_ADDR    byte address of word 0
//
// Ports
//   clk          single clock; all state changes on posedge
//   rest         synchronous active-high reset
//   req_valid    fetch request present
//   req_addr     byte fetch address (program-counter value)
//   req_ready    responder can accept a request (IDLE and not in reset)
//   rsp_valid    response word present
//   rsp_ready    consumer accepts the response
//   rsp_data     instruction word (zero on an errored fetch)
//   rsp_err      misaligned or out-of-range fetch
//   wr_en        program-load write strobe (honoured in any state, even in reset)
//   wr_addr      program-load byte address
//   wr_data      program-load word
//   fetch_count  number of completed responses, including errored ones; wraps
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | ready for a request; req_ready high unless in reset
// WAIT  | request accepted, down-counting the wait states
// RESP  | response presented, held until rsp_ready
// ---------------------------------------------------------------------------
module imem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'b0
) (
    input  logic        clk,
    input  logic        rest,
    input  logic        req_valid,
    input  logic [31:0] req_addr,
    output logic        req_ready,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    input  logic        wr_en,
    input  logic [31:0] wr_addr,
    input  logic [31:0] wr_data,
    output logic [31:0] fetch_count
);

    localparam int unsigned AW          = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    // The limit is held in 33 bits so that a store covering the full 4 GiB
    // space still compares correctly against a 32-bit offset.
    localparam logic [32:0] LIMIT_BYTES = 33'(DEPTH_WORDS) << 2;
    localparam logic [3:0]  WAIT_INIT   = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  wait_cnt_q, wait_cnt_d;
    logic [31:0] data_q, data_d;
    logic        err_q, err_d;
    logic [31:0] count_q, count_d;

    logic [31:0] mem_q [DEPTH_WORDS];

    logic [31:0] req_off;
    logic [31:0] wr_off;
    logic        req_bad;
    logic        wr_ok;
    logic [AW-1:0] req_idx;
    logic [AW-1:0] wr_idx;
    logic        accept;

    // Offsets are taken modulo 2^32. An address below BASE_ADDR therefore
    // wraps to a huge offset and is caught by the range check.
    assign req_off = req_addr - BASE_ADDR;
    assign wr_off  = wr_addr - BASE_ADDR;
    assign req_idx = req_off[AW+1:2];
    assign wr_idx  = wr_off[AW+1:2];

    assign req_bad = (req_addr[1:0] != 2'b00) || ({1'b0, req_off} >= LIMIT_BYTES);
    assign wr_ok   = (wr_addr[1:0] == 2'b00) && ({1'b0, wr_off} < LIMIT_BYTES);

    assign req_ready = (state_q == ST_IDLE) && !rest;
    assign accept    = req_valid && req_ready;

    // Program store. Reset does not touch it. A read at accept samples mem_q
    // before any same-edge write lands, which gives read-before-write.
    always_ff @(posedge clk) begin
        if (wr_en && wr_ok) begin
            mem_q[wr_idx] <= wr_data;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        data_d     = data_q;
        err_d      = err_q;
        count_d    = count_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    err_d  = req_bad;
                    data_d = req_bad ? 32'b0 : mem_q[req_idx];
                    if (WAIT_INIT == 4'd0) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d    = ST_WAIT;
                        wait_cnt_d = WAIT_INIT;
                    end
                end
            end

            ST_WAIT: begin
                // The count reaching 1 means the last wait state is in
                // progress, so RESP starts on the following cycle.
                if (wait_cnt_q <= 4'd1) begin
                    state_d    = ST_RESP;
                    wait_cnt_d = 4'd0;
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end

            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                    count_d = count_q + 32'd1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rest) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= 4'd0;
            data_q     <= 32'b0;
            err_q      <= 1'b0;
            count_q    <= 32'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            data_q     <= data_d;
            err_q      <= err_d;
            count_q    <= count_d;
        end
    end

    assign rsp_valid   = (state_q == ST_RESP);
    assign rsp_data    = data_q;
    assign rsp_err     = err_q;
    assign fetch_count = count_q;

endmodule

// File: tb/tb_imem_responder.sv
// ---------------------------------------------------------------------------
// tb_imem_responder
//
// Directed bench for imem_responder. Instance A uses the defaults (two wait
// states, 1024 words, base 0). Instance B uses zero wait states, 16 words and
// base 0x100, and exercises back-to-back fetches and the range boundaries.
// Inputs are driven 1 time unit after posedge. Outputs are sampled at least
// 1 time unit after that.
// ---------------------------------------------------------------------------
module tb_imem_responder;

    logic        clk = 1'b0;
    logic        rest;

    logic        req_valid, req_ready, rsp_valid, rsp_ready, rsp_err, wr_en;
    logic [31:0] req_addr, rsp_data, wr_addr, wr_data, fetch_count;

    logic        b_req_valid, b_req_ready, b_rsp_valid, b_rsp_ready, b_rsp_err, b_wr_en;
    logic [31:0] b_req_addr, b_rsp_data, b_wr_addr, b_wr_data, b_fetch_count;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_count = 32'd0;

    always #5 clk = ~clk;

    imem_responder u_dut_a (
        .clk         (clk),
        .rest        (rest),
        .req_valid   (req_valid),
        .req_addr    (req_addr),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_err     (rsp_err),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .fetch_count (fetch_count)
    );

    imem_responder #(
        .DEPTH_WORDS (16),
        .WAIT_CYCLES (0),
        .BASE_ADDR   (32'h0000_0100)
    ) u_dut_b (
        .clk         (clk),
        .rest        (rest),
        .req_valid   (b_req_valid),
        .req_addr    (b_req_addr),
        .req_ready   (b_req_ready),
        .rsp_valid   (b_rsp_valid),
        .rsp_ready   (b_rsp_ready),
        .rsp_data    (b_rsp_data),
        .rsp_err     (b_rsp_err),
        .wr_en       (b_wr_en),
        .wr_addr     (b_wr_addr),
        .wr_data     (b_wr_data),
        .fetch_count (b_fetch_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Full fetch on instance A with rsp_ready held at 1. Checks the latency,
    // the payload, the hold of fetch_count and the return to IDLE.
    task automatic do_fetch(input logic [31:0] addr, input logic [31:0] exp_data,
                            input logic exp_err, input string tag);
        int n;
        req_valid = 1'b1;
        req_addr  = addr;
        #1;
        n = 0;
        while (!req_ready && n < 20) begin
            cyc();
            n++;
        end
        chk({tag, "_acc"}, 32'(req_ready), 32'd1);
        cyc();
        req_valid = 1'b0;
        req_addr  = 32'b0;
        n = 1;
        while (!rsp_valid && n < 20) begin
            cyc();
            n++;
        end
        chk({tag, "_lat"},   32'(n),         32'd3);
        chk({tag, "_data"},  rsp_data,       exp_data);
        chk({tag, "_err"},   32'(rsp_err),   32'(exp_err));
        chk({tag, "_rdy"},   32'(req_ready), 32'd0);
        chk({tag, "_cnt0"},  fetch_count,    exp_count);
        cyc();
        exp_count = exp_count + 32'd1;
        chk({tag, "_cnt1"},  fetch_count,    exp_count);
        chk({tag, "_vld0"},  32'(rsp_valid), 32'd0);
        chk({tag, "_rdy1"},  32'(req_ready), 32'd1);
    endtask

    logic [31:0] a_wa [5];
    logic [31:0] a_wd [5];
    logic [31:0] b_wa [5];
    logic [31:0] b_wd [5];
    logic        b_we [5];
    logic [31:0] b_fa [5];
    logic [31:0] b_fd [5];
    logic        b_fe [5];

    initial begin
        a_wa[0] = 32'h0000_0000; a_wd[0] = 32'h2002_0005;
        a_wa[1] = 32'h0000_0004; a_wd[1] = 32'h3333_4444;
        a_wa[2] = 32'h0000_0008; a_wd[2] = 32'h1111_2222;
        a_wa[3] = 32'h0000_0006; a_wd[3] = 32'hFFFF_FFFF;
        a_wa[4] = 32'h0000_1000; a_wd[4] = 32'hFFFF_FFFF;
        b_wa[0] = 32'h0000_0104; b_wd[0] = 32'hABCD_0001; b_we[0] = 1'b1;
        b_wa[1] = 32'h0000_0108; b_wd[1] = 32'hABCD_0002; b_we[1] = 1'b1;
        b_wa[2] = 32'h0000_013C; b_wd[2] = 32'hABCD_000F; b_we[2] = 1'b1;
        b_wa[3] = 32'h0000_0140; b_wd[3] = 32'h5A5A_5A5A; b_we[3] = 1'b1;
        b_wa[4] = 32'h0000_0000; b_wd[4] = 32'h0000_0000; b_we[4] = 1'b0;
        b_fa[0] = 32'h0000_0104; b_fd[0] = 32'hABCD_0001; b_fe[0] = 1'b0;
        b_fa[1] = 32'h0000_013C; b_fd[1] = 32'hABCD_000F; b_fe[1] = 1'b0;
        b_fa[2] = 32'h0000_00FC; b_fd[2] = 32'h0000_0000; b_fe[2] = 1'b1;
        b_fa[3] = 32'h0000_0140; b_fd[3] = 32'h0000_0000; b_fe[3] = 1'b1;
        b_fa[4] = 32'h0000_0108; b_fd[4] = 32'hABCD_0002; b_fe[4] = 1'b0;

        rest = 1'b1;
        req_valid = 1'b0; req_addr = 32'b0; rsp_ready = 1'b1;
        wr_en = 1'b0; wr_addr = 32'b0; wr_data = 32'b0;
        b_req_valid = 1'b0; b_req_addr = 32'b0; b_rsp_ready = 1'b1;
        b_wr_en = 1'b0; b_wr_addr = 32'b0; b_wr_data = 32'b0;
        cyc();

        // Program load while reset is asserted. The misaligned and
        // out-of-range writes must be dropped.
        for (int i = 0; i < 5; i++) begin
            wr_en = 1'b1; wr_addr = a_wa[i]; wr_data = a_wd[i];
            b_wr_en = b_we[i]; b_wr_addr = b_wa[i]; b_wr_data = b_wd[i];
            cyc();
        end
        wr_en = 1'b0; b_wr_en = 1'b0;

        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data",  rsp_data,       32'd0);
        chk("rst_rsp_err",   32'(rsp_err),   32'd0);
        chk("rst_count",     fetch_count,    32'd0);

        rest = 1'b0;
        #1;
        chk("rel_req_ready", 32'(req_ready), 32'd1);
        cyc();

        do_fetch(32'h0000_0000, 32'h2002_0005, 1'b0, "f0");
        do_fetch(32'h0000_0006, 32'h0000_0000, 1'b1, "mis6");
        do_fetch(32'h0000_1000, 32'h0000_0000, 1'b1, "oor");
        do_fetch(32'h0000_0004, 32'h3333_4444, 1'b0, "f4");

        // Consumer stalls in RESP. A write to the same word during the
        // stall must not disturb the presented data.
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_addr = 32'h0000_0008;
        #1;
        chk("stall_acc", 32'(req_ready), 32'd1);
        cyc();
        req_valid = 1'b0;
        cyc();
        cyc();
        chk("stall_vld", 32'(rsp_valid), 32'd1);
        wr_en = 1'b1; wr_addr = 32'h0000_0008; wr_data = 32'h5555_6666;
        for (int i = 0; i < 5; i++) begin
            cyc();
            wr_en = 1'b0;
            chk("stall_hold_vld",  32'(rsp_valid), 32'd1);
            chk("stall_hold_data", rsp_data,       32'h1111_2222);
            chk("stall_hold_rdy",  32'(req_ready), 32'd0);
            chk("stall_hold_cnt",  fetch_count,    exp_count);
        end
        rsp_ready = 1'b1;
        cyc();
        exp_count = exp_count + 32'd1;
        chk("stall_cnt", fetch_count,    exp_count);
        chk("stall_end", 32'(rsp_valid), 32'd0);

        // Accept and write to the same word on the same edge: read-before-write.
        req_valid = 1'b1; req_addr = 32'h0000_0008;
        wr_en = 1'b1; wr_addr = 32'h0000_0008; wr_data = 32'hDEAD_BEEF;
        #1;
        chk("rbw_acc", 32'(req_ready), 32'd1);
        cyc();
        req_valid = 1'b0; wr_en = 1'b0;
        cyc();
        cyc();
        chk("rbw_vld",  32'(rsp_valid), 32'd1);
        chk("rbw_data", rsp_data,       32'h5555_6666);
        cyc();
        exp_count = exp_count + 32'd1;
        chk("rbw_cnt", fetch_count, exp_count);
        do_fetch(32'h0000_0008, 32'hDEAD_BEEF, 1'b0, "f8new");

        // Reset pulse during WAIT.
        req_valid = 1'b1; req_addr = 32'h0000_0000;
        #1;
        chk("rw_acc", 32'(req_ready), 32'd1);
        cyc();
        req_valid = 1'b0;
        chk("rw_wait", 32'(rsp_valid), 32'd0);
        rest = 1'b1;
        cyc();
        chk("rw_rdy_in_rst", 32'(req_ready), 32'd0);
        rest = 1'b0;
        #1;
        exp_count = 32'd0;
        chk("rw_rdy", 32'(req_ready), 32'd1);
        chk("rw_cnt", fetch_count,    exp_count);
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("rw_no_rsp", 32'(rsp_valid), 32'd0);
        end
        do_fetch(32'h0000_0000, 32'h2002_0005, 1'b0, "rw_f0");

        // Reset during a stalled RESP, arriving together with rsp_ready.
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_addr = 32'h0000_0004;
        #1;
        cyc();
        req_valid = 1'b0;
        cyc();
        cyc();
        chk("rr_vld", 32'(rsp_valid), 32'd1);
        rest = 1'b1; rsp_ready = 1'b1;
        cyc();
        rest = 1'b0;
        exp_count = 32'd0;
        #1;
        chk("rr_cnt",  fetch_count,    exp_count);
        chk("rr_vld0", 32'(rsp_valid), 32'd0);
        chk("rr_data", rsp_data,       32'd0);
        chk("rr_rdy",  32'(req_ready), 32'd1);
        cyc();

        // Instance B: zero wait states, back-to-back fetches, one accept
        // every two cycles. The address table covers the base offset and
        // both ends of the range.
        b_req_valid = 1'b1;
        b_req_addr  = b_fa[0];
        #1;
        for (int i = 0; i < 5; i++) begin
            chk("b_rdy",  32'(b_req_ready), 32'd1);
            chk("b_idle", 32'(b_rsp_valid), 32'd0);
            cyc();
            chk("b_vld",  32'(b_rsp_valid), 32'd1);
            chk("b_data", b_rsp_data,       b_fd[i]);
            chk("b_err",  32'(b_rsp_err),   32'(b_fe[i]));
            chk("b_busy", 32'(b_req_ready), 32'd0);
            if (i < 4) begin
                b_req_addr = b_fa[i + 1];
            end else begin
                b_req_valid = 1'b0;
            end
            cyc();
        end
        chk("b_cnt",  b_fetch_count,    32'd5);
        chk("b_done", 32'(b_rsp_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
